// File: rtl/usb_fifo_pkg.sv
// Shared register map, status/control bit positions and FSM state type for usb_stream_fifo_bank.
package usb_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LEVEL  = 2'd2;
  localparam logic [1:0] REG_ZERO   = 2'd3;

  // STATUS flag bits sit at DATA_W minus these offsets
  localparam int unsigned STAT_OVF_OFS     = 1;
  localparam int unsigned STAT_UDF_OFS     = 2;
  localparam int unsigned STAT_DN_FULL_OFS = 3;

  localparam int unsigned CTRL_FLUSH_UP = 0;
  localparam int unsigned CTRL_FLUSH_DN = 1;
  localparam int unsigned CTRL_CLR_ERR  = 2;

  typedef enum logic {
    AVS_IDLE  = 1'b0,
    AVS_RDATA = 1'b1
  } avs_state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with flush, level count and registered read data (zero when no pop).
module sync_fifo_core #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = rdata_q;

  // Flush overrides both operations in the same cycle
  assign push_ok = push_i & ~full_o  & ~flush_i;
  assign pop_ok  = pop_i  & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rdata_q <= pop_ok ? mem_q[rd_ptr_q] : '0;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
      end
    end
  end

endmodule

// File: rtl/usb_stream_fifo_bank.sv
// Multi-channel up/down FIFO bank bridging user logic and an Avalon-MM USB host driver.
module usb_stream_fifo_bank
  import usb_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned NUM_CH     = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic                          usb_write_en,
  input  logic [ch_width(NUM_CH)-1:0]   usb_write_ch,
  input  logic [DATA_W-1:0]             usb_write_data,
  output logic                          usb_write_wait,
  input  logic                          usb_read_en,
  input  logic [ch_width(NUM_CH)-1:0]   usb_read_ch,
  output logic                          usb_read_wait,
  output logic [DATA_W-1:0]             usb_read_data,
  output logic                          usb_read_valid,
  input  logic [ch_width(NUM_CH)+1:0]   avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [DATA_W-1:0]             avs_writedata,
  output logic [DATA_W-1:0]             avs_readdata,
  output logic                          avs_waitrequest
);

  localparam int unsigned CH_W     = ch_width(NUM_CH);
  localparam int unsigned NCH_P    = 1 << CH_W;
  localparam int unsigned LVL_W    = DEPTH_LOG2 + 1;
  localparam int unsigned ST_OVF   = DATA_W - STAT_OVF_OFS;
  localparam int unsigned ST_UDF   = DATA_W - STAT_UDF_OFS;
  localparam int unsigned ST_DFULL = DATA_W - STAT_DN_FULL_OFS;

  logic [NCH_P-1:0]  up_full, up_empty, dn_full, dn_empty;
  logic [LVL_W-1:0]  up_level [NCH_P];
  logic [LVL_W-1:0]  dn_level [NCH_P];
  logic [DATA_W-1:0] up_rdata [NCH_P];
  logic [DATA_W-1:0] dn_rdata [NCH_P];

  logic [CH_W-1:0]   avs_ch;
  logic [1:0]        avs_reg;
  logic              rd_start, wr_data, wr_ctrl;

  avs_state_e        state_q, state_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rd_is_data_q;
  logic [CH_W-1:0]   avs_ch_q;
  logic [NCH_P-1:0]  udf_q, udf_d, ovf_q, ovf_d;
  logic              usb_read_valid_q;
  logic [CH_W-1:0]   rd_ch_q;

  assign {avs_ch, avs_reg} = avs_address;
  assign rd_start = (state_q == AVS_IDLE) & avs_read;
  assign wr_data  = avs_write & (avs_reg == REG_DATA);
  assign wr_ctrl  = avs_write & (avs_reg == REG_STATUS);

  // Channel lanes; padding lanes above NUM_CH look permanently full and empty
  for (genvar c = 0; c < NCH_P; c++) begin : g_ch
    if (c < NUM_CH) begin : g_fifo
      sync_fifo_core #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_up (
        .clk         (CLOCK_50),
        .rst_n       (rst_n),
        .push_i      (usb_write_en & (usb_write_ch == CH_W'(c))),
        .push_data_i (usb_write_data),
        .pop_i       (rd_start & (avs_reg == REG_DATA) & (avs_ch == CH_W'(c))),
        .flush_i     (wr_ctrl & (avs_ch == CH_W'(c)) & avs_writedata[CTRL_FLUSH_UP]),
        .full_o      (up_full[c]),
        .empty_o     (up_empty[c]),
        .level_o     (up_level[c]),
        .rdata_o     (up_rdata[c])
      );
      sync_fifo_core #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_dn (
        .clk         (CLOCK_50),
        .rst_n       (rst_n),
        .push_i      (wr_data & (avs_ch == CH_W'(c))),
        .push_data_i (avs_writedata),
        .pop_i       (usb_read_en & (usb_read_ch == CH_W'(c))),
        .flush_i     (wr_ctrl & (avs_ch == CH_W'(c)) & avs_writedata[CTRL_FLUSH_DN]),
        .full_o      (dn_full[c]),
        .empty_o     (dn_empty[c]),
        .level_o     (dn_level[c]),
        .rdata_o     (dn_rdata[c])
      );
    end else begin : g_pad
      assign up_full[c]  = 1'b1;
      assign up_empty[c] = 1'b1;
      assign dn_full[c]  = 1'b1;
      assign dn_empty[c] = 1'b1;
      assign up_level[c] = '0;
      assign dn_level[c] = '0;
      assign up_rdata[c] = '0;
      assign dn_rdata[c] = '0;
    end
  end

  assign usb_write_wait = up_full[usb_write_ch];
  assign usb_read_wait  = dn_empty[usb_read_ch];
  assign usb_read_valid = usb_read_valid_q;
  assign usb_read_data  = dn_rdata[rd_ch_q];

  assign avs_waitrequest = rd_start;
  assign avs_readdata    = rd_is_data_q ? up_rdata[avs_ch_q] : readdata_q;

  // Avalon read FSM, register snapshot and sticky error flags
  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    udf_d      = udf_q;
    ovf_d      = ovf_q;

    if (wr_ctrl && avs_writedata[CTRL_CLR_ERR]) begin
      udf_d[avs_ch] = 1'b0;
      ovf_d[avs_ch] = 1'b0;
    end
    if (rd_start && (avs_reg == REG_DATA) && up_empty[avs_ch]) udf_d[avs_ch] = 1'b1;
    if (wr_data && dn_full[avs_ch]) ovf_d[avs_ch] = 1'b1;

    case (state_q)
      AVS_IDLE: begin
        if (avs_read) begin
          state_d    = AVS_RDATA;
          readdata_d = '0;
          case (avs_reg)
            REG_STATUS: begin
              readdata_d[LVL_W-1:0] = up_level[avs_ch];
              readdata_d[ST_DFULL]  = dn_full[avs_ch];
              readdata_d[ST_UDF]    = udf_q[avs_ch];
              readdata_d[ST_OVF]    = ovf_q[avs_ch];
            end
            REG_LEVEL: readdata_d = DATA_W'(dn_level[avs_ch]);
            default:   readdata_d = '0;
          endcase
        end
      end
      AVS_RDATA: state_d = AVS_IDLE;
      default:   state_d = AVS_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= AVS_IDLE;
      readdata_q       <= '0;
      rd_is_data_q     <= 1'b0;
      avs_ch_q         <= '0;
      udf_q            <= '0;
      ovf_q            <= '0;
      usb_read_valid_q <= 1'b0;
      rd_ch_q          <= '0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
      udf_q      <= udf_d;
      ovf_q      <= ovf_d;
      if (rd_start) begin
        rd_is_data_q <= (avs_reg == REG_DATA);
        avs_ch_q     <= avs_ch;
      end
      if (usb_read_en) rd_ch_q <= usb_read_ch;
      usb_read_valid_q <= usb_read_en & ~usb_read_wait &
                          ~(wr_ctrl & (avs_ch == usb_read_ch) & avs_writedata[CTRL_FLUSH_DN]);
    end
  end

endmodule

// File: tb/tb_usb_stream_fifo_bank.sv
// Directed self-checking bench for usb_stream_fifo_bank (DATA_W=16, DEPTH_LOG2=6, NUM_CH=2).
module tb_usb_stream_fifo_bank;

  localparam int unsigned AW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        usb_write_en, usb_read_en;
  logic [0:0]  usb_write_ch, usb_read_ch;
  logic [15:0] usb_write_data, usb_read_data;
  logic        usb_write_wait, usb_read_wait, usb_read_valid;
  logic [AW-1:0] avs_address;
  logic        avs_read, avs_write, avs_waitrequest;
  logic [15:0] avs_writedata, avs_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  usb_stream_fifo_bank #(.DATA_W(16), .DEPTH_LOG2(6), .NUM_CH(2)) dut (
    .CLOCK_50        (clk),
    .rst_n           (rst_n),
    .usb_write_en    (usb_write_en),
    .usb_write_ch    (usb_write_ch),
    .usb_write_data  (usb_write_data),
    .usb_write_wait  (usb_write_wait),
    .usb_read_en     (usb_read_en),
    .usb_read_ch     (usb_read_ch),
    .usb_read_wait   (usb_read_wait),
    .usb_read_data   (usb_read_data),
    .usb_read_valid  (usb_read_valid),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic user_push(input logic ch, input logic [15:0] d);
    usb_write_en = 1'b1; usb_write_ch = ch; usb_write_data = d;
    tick();
    usb_write_en = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [15:0] d);
    avs_write = 1'b1; avs_address = addr; avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  // Bounded Avalon read; returns data and number of stalled cycles
  task automatic host_read(input logic [AW-1:0] addr, output logic [15:0] d, output int waits);
    bit done;
    done = 1'b0; waits = 0; d = '0;
    avs_address = addr; avs_read = 1'b1;
    for (int i = 0; i < 4 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin d = avs_readdata; done = 1'b1; end
      else waits++;
      tick();
    end
    avs_read = 1'b0;
  endtask

  task automatic host_rd_chk(input string tag, input logic [AW-1:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    int w;
    host_read(addr, d, w);
    check({tag, "_data"}, d, exp);
    check({tag, "_wait"}, w, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    usb_write_en = 0; usb_write_ch = 0; usb_write_data = 0;
    usb_read_en = 0; usb_read_ch = 0;
    avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_write_wait", usb_write_wait, 0);
    check("rst_read_wait", usb_read_wait, 1);
    check("rst_read_valid", usb_read_valid, 0);
    check("rst_read_data", usb_read_data, 0);
    check("rst_readdata", avs_readdata, 0);
    check("rst_waitreq", avs_waitrequest, 0);

    // Two words up on ch1, then host drains them in order
    user_push(1'b1, 16'h1234);
    user_push(1'b1, 16'h5678);
    host_rd_chk("ch1_status", 3'b101, 16'h0002);
    host_rd_chk("ch1_data0", 3'b100, 16'h1234);
    host_rd_chk("ch1_data1", 3'b100, 16'h5678);

    // Fill ch0 up FIFO, 65th push ignored
    for (int i = 0; i < 64; i++) user_push(1'b0, 16'(16'h0100 + i));
    usb_write_ch = 1'b0;
    #1 check("ch0_full_wait", usb_write_wait, 1);
    usb_write_ch = 1'b1;
    #1 check("ch1_wait_free", usb_write_wait, 0);
    user_push(1'b0, 16'hDEAD);
    host_rd_chk("ch0_level64", 3'b001, 16'h0040);

    // Full: push blocked even with a same-cycle host pop
    avs_address = 3'b000; avs_read = 1'b1;
    usb_write_en = 1'b1; usb_write_ch = 1'b0; usb_write_data = 16'hBEEF;
    @(negedge clk);
    check("pp_waitreq1", avs_waitrequest, 1);
    tick();
    usb_write_en = 1'b0;
    @(negedge clk);
    check("pp_waitreq0", avs_waitrequest, 0);
    check("pp_data", avs_readdata, 16'h0100);
    tick();
    avs_read = 1'b0;
    host_rd_chk("ch0_level63", 3'b001, 16'h003F);

    // Flush up ch0 coincident with a user push
    usb_write_en = 1'b1; usb_write_ch = 1'b0; usb_write_data = 16'hCAFE;
    host_write(3'b001, 16'h0001);
    usb_write_en = 1'b0;
    host_rd_chk("ch0_flushed", 3'b001, 16'h0000);

    // Empty read underflow, then clear
    host_rd_chk("ch0_empty_rd", 3'b000, 16'h0000);
    host_rd_chk("ch0_udf", 3'b001, 16'h4000);
    host_write(3'b001, 16'h0004);
    host_rd_chk("ch0_udf_clr", 3'b001, 16'h0000);
    host_rd_chk("reg3_zero", 3'b011, 16'h0000);

    // Overfill ch1 down FIFO
    for (int i = 0; i < 65; i++) host_write(3'b100, 16'(16'hA000 + i));
    host_rd_chk("ch1_ovf_status", 3'b101, 16'hA000);
    host_rd_chk("ch1_dn_level", 3'b110, 16'h0040);
    usb_read_ch = 1'b1;
    #1 check("ch1_rd_wait0", usb_read_wait, 0);

    // User drains ch1 back-to-back
    usb_read_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      check("pop_valid", usb_read_valid, 1);
      check("pop_data", usb_read_data, 16'(16'hA000 + i));
    end
    usb_read_en = 1'b0;
    check("ch1_rd_wait1", usb_read_wait, 1);
    tick();
    check("pop_valid_end", usb_read_valid, 0);
    usb_read_en = 1'b1;
    tick();
    usb_read_en = 1'b0;
    check("pop_empty_valid", usb_read_valid, 0);
    host_write(3'b101, 16'h0004);
    host_rd_chk("ch1_ovf_clr", 3'b101, 16'h0000);

    // Flush down ch0 coincident with a user pop
    host_write(3'b000, 16'h5555);
    host_write(3'b000, 16'h6666);
    usb_read_ch = 1'b0; usb_read_en = 1'b1;
    host_write(3'b001, 16'h0002);
    usb_read_en = 1'b0;
    check("flush_pop_valid", usb_read_valid, 0);
    check("flush_pop_data", usb_read_data, 0);
    check("flush_dn_empty", usb_read_wait, 1);

    // Reset mid-burst
    host_write(3'b000, 16'h7777);
    host_write(3'b000, 16'h8888);
    usb_read_en = 1'b1; usb_read_ch = 1'b0;
    usb_write_en = 1'b1; usb_write_ch = 1'b0; usb_write_data = 16'h9999;
    tick();
    check("burst_valid", usb_read_valid, 1);
    check("burst_data", usb_read_data, 16'h7777);
    #2 rst_n = 1'b0;
    #1 check("midrst_valid", usb_read_valid, 0);
    check("midrst_data", usb_read_data, 0);
    usb_read_en = 1'b0; usb_write_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_rd_wait", usb_read_wait, 1);
    host_rd_chk("postrst_up_lvl", 3'b001, 16'h0000);
    host_rd_chk("postrst_dn_lvl", 3'b010, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
